// File: rtl/soc_region_pkg.sv
// soc_region_pkg: shared types, attribute bit positions, config offsets and
// the default SoC address map used to reload the region table on reset.
package soc_region_pkg;

    // Attribute byte bit positions
    localparam int AttrValidBit   = 0;
    localparam int AttrCachedBit  = 1;
    localparam int AttrExecBit    = 2;
    localparam int AttrNonIdemBit = 3;
    localparam int AttrLockBit    = 7;

    // Bits 6:4 are reserved: dropped on write so they always read back 0
    localparam logic [7:0] AttrWriteMask = 8'((1 << AttrValidBit) | (1 << AttrCachedBit) |
                                              (1 << AttrExecBit)  | (1 << AttrNonIdemBit) |
                                              (1 << AttrLockBit));

    localparam logic [7:0] AttrDevice = 8'((1 << AttrValidBit) | (1 << AttrNonIdemBit));
    localparam logic [7:0] AttrDram   = 8'((1 << AttrValidBit) | (1 << AttrCachedBit) |
                                           (1 << AttrExecBit));

    typedef struct packed {
        logic       lock;
        logic [2:0] rsvd;
        logic       non_idem;
        logic       exec;
        logic       cached;
        logic       valid;
    } region_attr_t;

    typedef struct packed {
        logic [63:0]  base;
        logic [63:0]  length;
        region_attr_t attr;
    } region_rule_t;

    // Config space: 32-byte stride per entry, field selected by addr[4:3]
    localparam int          CfgEntryStride = 32;
    localparam logic [1:0]  CfgFieldBase   = 2'd0;  // +0x00
    localparam logic [1:0]  CfgFieldLength = 2'd1;  // +0x08
    localparam logic [1:0]  CfgFieldAttr   = 2'd2;  // +0x10
    localparam logic [1:0]  CfgFieldCount  = 2'd3;  // +0x18
    localparam logic [11:0] CfgMissCntAddr = 12'h3F8;

    localparam int NumDefaultRegions = 11;
    localparam int DramIdx           = 10;

    typedef region_rule_t [NumDefaultRegions-1:0] region_map_t;

    function automatic region_rule_t make_rule(input logic [63:0] base,
                                               input logic [63:0] length,
                                               input logic [7:0]  attr);
        region_rule_t rule;
        rule.base   = base;
        rule.length = length;
        rule.attr   = region_attr_t'(attr);
        return rule;
    endfunction

    function automatic region_map_t build_default_map();
        region_map_t m;
        m[0]       = make_rule(64'h0000_0000, 64'h0000_1000, AttrDevice);  // Debug
        m[1]       = make_rule(64'h0001_0000, 64'h0001_0000, AttrDevice);  // ROM
        m[2]       = make_rule(64'h0200_0000, 64'h000C_0000, AttrDevice);  // CLINT
        m[3]       = make_rule(64'h0C00_0000, 64'h0400_0000, AttrDevice);  // PLIC
        m[4]       = make_rule(64'h1000_0000, 64'h0000_1000, AttrDevice);  // UART
        m[5]       = make_rule(64'h1800_0000, 64'h0000_1000, AttrDevice);  // Timer
        m[6]       = make_rule(64'h2000_0000, 64'h0080_0000, AttrDevice);  // SPI
        m[7]       = make_rule(64'h3000_0000, 64'h0001_0000, AttrDevice);  // Ethernet
        m[8]       = make_rule(64'h4000_0000, 64'h0000_1000, AttrDevice);  // GPIO
        m[9]       = make_rule(64'h5000_0000, 64'h0000_1000, AttrDevice);  // DMA
        m[DramIdx] = make_rule(64'h8000_0000, 64'h4000_0000, AttrDram);    // DRAM
        return m;
    endfunction

    localparam region_map_t DefaultMap = build_default_map();

endpackage

// File: rtl/soc_region_prio_enc.sv
// soc_region_prio_enc: lowest-index-wins priority encoder over a match vector.
module soc_region_prio_enc #(
    parameter int N        = 11,
    parameter int IdxWidth = $clog2(N)
) (
    input  logic [N-1:0]        match_i,
    output logic                hit_o,
    output logic [IdxWidth-1:0] idx_o
);

    // Scan from the top so the lowest set bit is the last (winning) assignment
    always_comb begin
        // NOTE: outputs get defaults before any conditional so no latch is inferred.
        hit_o = |match_i;
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (match_i[i]) begin
                idx_o = IdxWidth'(i);
            end
        end
    end

endmodule

// File: rtl/soc_region_map.sv
// soc_region_map: programmable address map with a 2-stage lookup pipeline.
// Optional hit/miss counters are built when REGION_MAP_STATS_EN is defined.
// With NumRegions = 32 the miss counter at 0x3F8 shadows entry 31's counter.
module soc_region_map
    import soc_region_pkg::*;
#(
    parameter int NumRegions     = 11,
    parameter int AddrWidth      = 64,
    parameter int RegionIdxWidth = $clog2(NumRegions),
    parameter region_rule_t [NumRegions-1:0] ResetMap = DefaultMap
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cfg_req_i,
    input  logic                      cfg_we_i,
    input  logic [11:0]               cfg_addr_i,
    input  logic [63:0]               cfg_wdata_i,
    output logic                      cfg_rvalid_o,
    output logic [63:0]               cfg_rdata_o,
    output logic                      cfg_err_o,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [AddrWidth-1:0]      req_addr_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic                      resp_hit_o,
    output logic [RegionIdxWidth-1:0] resp_idx_o,
    output logic [7:0]                resp_attr_o
);

    // Region table
    logic [AddrWidth-1:0] base_q [NumRegions];
    logic [AddrWidth-1:0] base_d [NumRegions];
    logic [AddrWidth-1:0] len_q  [NumRegions];
    logic [AddrWidth-1:0] len_d  [NumRegions];
    region_attr_t         attr_q [NumRegions];
    region_attr_t         attr_d [NumRegions];

    // Config response
    logic        cfg_rvalid_q, cfg_rvalid_d;
    logic        cfg_err_q, cfg_err_d;
    logic [63:0] cfg_rdata_q, cfg_rdata_d;

    // Config decode
    logic       cfg_aligned, cfg_is_miss, cfg_in_range, cfg_entry_ok, cfg_wr_ok;
    logic [6:0] cfg_entry;
    logic [1:0] cfg_field;

    // Pipeline
    logic                      ready_en_q, ready_en_d;
    logic                      s1_valid_q, s1_valid_d;
    logic [NumRegions-1:0]     s1_match_q, s1_match_d;
    region_attr_t              s1_attr_q [NumRegions];
    region_attr_t              s1_attr_d [NumRegions];
    logic                      s2_valid_q, s2_valid_d;
    logic                      s2_hit_q, s2_hit_d;
    logic [RegionIdxWidth-1:0] s2_idx_q, s2_idx_d;
    logic [7:0]                s2_attr_q, s2_attr_d;

    logic                      s1_load, s2_load, resp_fire, req_fire;
    logic [AddrWidth-1:0]      addr_off [NumRegions];
    logic [NumRegions-1:0]     match;
    logic                      enc_hit;
    logic [RegionIdxWidth-1:0] enc_idx;

`ifdef REGION_MAP_STATS_EN
    logic [31:0] hit_cnt_q [NumRegions];
    logic [31:0] hit_cnt_d [NumRegions];
    logic [31:0] miss_cnt_q, miss_cnt_d;
`endif

    // Decode the config address into entry/field and legality flags
    always_comb begin
        cfg_aligned  = (cfg_addr_i[2:0] == 3'b000);
        cfg_is_miss  = (cfg_addr_i == CfgMissCntAddr);
        cfg_in_range = (cfg_addr_i < 12'(NumRegions * CfgEntryStride));
        cfg_entry    = cfg_addr_i[11:5];
        cfg_field    = cfg_addr_i[4:3];
        cfg_entry_ok = cfg_aligned && !cfg_is_miss && cfg_in_range;
        cfg_wr_ok    = cfg_req_i && cfg_we_i && cfg_aligned;
    end

    // Config access: table writes (lock-protected), read mux and error response
    always_comb begin
        cfg_rvalid_d = cfg_req_i;
        cfg_err_d    = 1'b0;
        cfg_rdata_d  = '0;
        base_d       = base_q;
        len_d        = len_q;
        attr_d       = attr_q;
        if (cfg_req_i) begin
            if (!cfg_aligned) begin
                cfg_err_d = 1'b1;
            end else if (cfg_is_miss) begin
`ifdef REGION_MAP_STATS_EN
                if (!cfg_we_i) cfg_rdata_d = 64'(miss_cnt_q);
`endif
            end else if (!cfg_in_range) begin
                cfg_err_d = 1'b1;
            end else begin
                for (int r = 0; r < NumRegions; r++) begin
                    if (cfg_entry == 7'(r)) begin
                        if (cfg_we_i) begin
                            // Counter clears bypass the lock and live in the stats block
                            if (cfg_field != CfgFieldCount) begin
                                if (attr_q[r].lock) begin
                                    cfg_err_d = 1'b1;
                                end else begin
                                    case (cfg_field)
                                        CfgFieldBase:   base_d[r] = cfg_wdata_i[AddrWidth-1:0];
                                        CfgFieldLength: len_d[r]  = cfg_wdata_i[AddrWidth-1:0];
                                        CfgFieldAttr:   attr_d[r] = region_attr_t'(cfg_wdata_i[7:0] & AttrWriteMask);
                                        default: ;
                                    endcase
                                end
                            end
                        end else begin
                            case (cfg_field)
                                CfgFieldBase:   cfg_rdata_d = 64'(base_q[r]);
                                CfgFieldLength: cfg_rdata_d = 64'(len_q[r]);
                                CfgFieldAttr:   cfg_rdata_d = 64'(attr_q[r]);
`ifdef REGION_MAP_STATS_EN
                                CfgFieldCount:  cfg_rdata_d = 64'(hit_cnt_q[r]);
`endif
                                default: ;
                            endcase
                        end
                    end
                end
            end
        end
    end

    // Per-entry modular range match against the pre-write table
    always_comb begin
        for (int r = 0; r < NumRegions; r++) begin
            addr_off[r] = req_addr_i - base_q[r];
            match[r]    = attr_q[r].valid && (len_q[r] != '0) && (addr_off[r] < len_q[r]);
        end
    end

    soc_region_prio_enc #(
        .N        (NumRegions),
        .IdxWidth (RegionIdxWidth)
    ) u_prio_enc (
        .match_i (s1_match_q),
        .hit_o   (enc_hit),
        .idx_o   (enc_idx)
    );

    // Handshake and stage advance: S2 loads when empty or draining, S1 when S2 moves
    always_comb begin
        resp_fire   = s2_valid_q && resp_ready_i;
        s2_load     = !s2_valid_q || resp_ready_i;
        s1_load     = !s1_valid_q || s2_load;
        req_ready_o = ready_en_q && s1_load;
        req_fire    = req_valid_i && req_ready_o;
        ready_en_d  = 1'b1;

        s1_valid_d = s1_valid_q;
        s1_match_d = s1_match_q;
        s1_attr_d  = s1_attr_q;
        if (s1_load) begin
            s1_valid_d = req_fire;
            if (req_fire) begin
                s1_match_d = match;
                s1_attr_d  = attr_q;
            end
        end

        s2_valid_d = s2_valid_q;
        s2_hit_d   = s2_hit_q;
        s2_idx_d   = s2_idx_q;
        s2_attr_d  = s2_attr_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_hit_d  = enc_hit;
                s2_idx_d  = enc_idx;
                s2_attr_d = enc_hit ? 8'(s1_attr_q[enc_idx]) : 8'h00;
            end
        end
    end

    // Table, config response and pipeline control registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NumRegions; r++) begin
                // NOTE: the table is architectural state, so every entry reloads from ResetMap.
                base_q[r] <= ResetMap[r].base[AddrWidth-1:0];
                len_q[r]  <= ResetMap[r].length[AddrWidth-1:0];
                attr_q[r] <= ResetMap[r].attr;
            end
            cfg_rvalid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            cfg_rdata_q  <= '0;
            ready_en_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_hit_q     <= 1'b0;
            s2_idx_q     <= '0;
            s2_attr_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            base_q       <= base_d;
            len_q        <= len_d;
            attr_q       <= attr_d;
            cfg_rvalid_q <= cfg_rvalid_d;
            cfg_err_q    <= cfg_err_d;
            cfg_rdata_q  <= cfg_rdata_d;
            ready_en_q   <= ready_en_d;
            s1_valid_q   <= s1_valid_d;
            s2_valid_q   <= s2_valid_d;
            s2_hit_q     <= s2_hit_d;
            s2_idx_q     <= s2_idx_d;
            s2_attr_q    <= s2_attr_d;
        end
    end

    // S1 payload is qualified by s1_valid_q and needs no reset
    always_ff @(posedge clk_i) begin
        s1_match_q <= s1_match_d;
        s1_attr_q  <= s1_attr_d;
    end

`ifdef REGION_MAP_STATS_EN
    // Saturating hit/miss counters on accepted results; config writes clear them
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (resp_fire) begin
            if (s2_hit_q) begin
                for (int r = 0; r < NumRegions; r++) begin
                    if ((s2_idx_q == RegionIdxWidth'(r)) && (hit_cnt_q[r] != '1)) begin
                        hit_cnt_d[r] = hit_cnt_q[r] + 32'd1;
                    end
                end
            end else if (miss_cnt_q != '1) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
        if (cfg_wr_ok && cfg_is_miss) miss_cnt_d = '0;
        for (int r = 0; r < NumRegions; r++) begin
            if (cfg_wr_ok && cfg_entry_ok && (cfg_entry == 7'(r)) && (cfg_field == CfgFieldCount)) begin
                hit_cnt_d[r] = '0;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NumRegions; r++) hit_cnt_q[r] <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif

    assign cfg_rvalid_o = cfg_rvalid_q;
    assign cfg_err_o    = cfg_err_q;
    assign cfg_rdata_o  = cfg_rdata_q;
    assign resp_valid_o = s2_valid_q;
    assign resp_hit_o   = s2_hit_q;
    assign resp_idx_o   = s2_idx_q;
    assign resp_attr_o  = s2_attr_q;

endmodule

// File: tb/tb_soc_region_map.sv
// tb_soc_region_map: directed self-checking bench for soc_region_map.
module tb_soc_region_map;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_req, cfg_we;
    logic [11:0] cfg_addr;
    logic [63:0] cfg_wdata;
    logic        cfg_rvalid, cfg_err;
    logic [63:0] cfg_rdata;
    logic        req_valid, req_ready;
    logic [63:0] req_addr;
    logic        resp_valid, resp_ready, resp_hit;
    logic [3:0]  resp_idx;
    logic [7:0]  resp_attr;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    soc_region_map dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_req_i    (cfg_req),
        .cfg_we_i     (cfg_we),
        .cfg_addr_i   (cfg_addr),
        .cfg_wdata_i  (cfg_wdata),
        .cfg_rvalid_o (cfg_rvalid),
        .cfg_rdata_o  (cfg_rdata),
        .cfg_err_o    (cfg_err),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_hit_o   (resp_hit),
        .resp_idx_o   (resp_idx),
        .resp_attr_o  (resp_attr)
    );

    // Stimulus helpers: all start and end shortly after a rising edge
    task automatic cfg_write(input logic [11:0] a, input logic [63:0] d, output logic err);
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_req = 1'b0; cfg_we = 1'b0;
        err = cfg_rvalid ? cfg_err : 1'bx;
    endtask

    task automatic cfg_read(input logic [11:0] a, output logic [63:0] d, output logic err);
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = a;
        @(posedge clk); #1;
        cfg_req = 1'b0;
        d   = cfg_rvalid ? cfg_rdata : 64'hx;
        err = cfg_rvalid ? cfg_err : 1'bx;
    endtask

    // Single lookup; lat counts edges from the handshake edge to resp_valid
    task automatic lookup(input logic [63:0] a, output logic hit, output logic [3:0] idx,
                          output logic [7:0] attr, output int lat);
        int n;
        resp_ready = 1'b1; req_valid = 1'b1; req_addr = a; #1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1; hit = 1'bx; idx = 'x; attr = 'x;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (resp_valid) begin
                lat = c; hit = resp_hit; idx = resp_idx; attr = resp_attr;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [63:0] d; logic e;
        rst = 1'b1; cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({req_ready, resp_valid, cfg_rvalid, cfg_err} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 0000", {req_ready, resp_valid, cfg_rvalid, cfg_err});
        end
        tests_run++;
        if ({cfg_rdata, resp_hit, resp_idx, resp_attr} !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h/%b/%h/%h expected all zero", cfg_rdata, resp_hit, resp_idx, resp_attr);
        end
        rst = 1'b0; #1;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++; $display("FAIL ready_early: got %b expected 0", req_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL ready_after_reset: got %b expected 1", req_ready);
        end
        cfg_read(12'h140, d, e);
        tests_run++;
        if ({e, d} !== {1'b0, 64'h8000_0000}) begin
            tests_failed++; $display("FAIL default_dram_base: got err=%b %h expected err=0 %h", e, d, 64'h8000_0000);
        end
        cfg_read(12'h148, d, e);
        tests_run++;
        if ({e, d} !== {1'b0, 64'h4000_0000}) begin
            tests_failed++; $display("FAIL default_dram_len: got err=%b %h expected err=0 %h", e, d, 64'h4000_0000);
        end
    endtask

    task automatic test_dram_lookup();
        logic h; logic [3:0] i; logic [7:0] a; int lat; logic [63:0] d; logic e;
        lookup(64'h8000_1000, h, i, a, lat);
        tests_run++;
        if ({h, i, a} !== {1'b1, 4'd10, 8'h07}) begin
            tests_failed++; $display("FAIL dram_lookup: got %b/%0d/%h expected 1/10/07", h, i, a);
        end
        tests_run++;
        if (lat !== 2) begin
            tests_failed++; $display("FAIL dram_latency: got %0d expected 2", lat);
        end
        cfg_read(12'h158, d, e);
        tests_run++;
`ifdef REGION_MAP_STATS_EN
        if ({e, d} !== {1'b0, 64'd1}) begin
            tests_failed++; $display("FAIL dram_hit_cnt: got err=%b %0d expected err=0 1", e, d);
        end
        cfg_write(12'h158, 64'h0, e);
        cfg_read(12'h158, d, e);
        tests_run++;
        if ({e, d} !== {1'b0, 64'd0}) begin
            tests_failed++; $display("FAIL dram_hit_clr: got err=%b %0d expected err=0 0", e, d);
        end
`else
        if ({e, d} !== {1'b0, 64'd0}) begin
            tests_failed++; $display("FAIL dram_hit_cnt: got err=%b %0d expected err=0 0", e, d);
        end
`endif
    endtask

    task automatic test_miss();
        logic h; logic [3:0] i; logic [7:0] a; int lat; logic [63:0] d; logic e;
        lookup(64'h6000_0000, h, i, a, lat);
        tests_run++;
        if ({h, i, a} !== {1'b0, 4'd0, 8'h00} || lat !== 2) begin
            tests_failed++; $display("FAIL miss_lookup: got %b/%0d/%h lat %0d expected 0/0/00 lat 2", h, i, a, lat);
        end
        cfg_read(12'h3F8, d, e);
        tests_run++;
`ifdef REGION_MAP_STATS_EN
        if ({e, d} !== {1'b0, 64'd1}) begin
            tests_failed++; $display("FAIL miss_cnt: got err=%b %0d expected err=0 1", e, d);
        end
`else
        if ({e, d} !== {1'b0, 64'd0}) begin
            tests_failed++; $display("FAIL miss_cnt: got err=%b %0d expected err=0 0", e, d);
        end
`endif
    endtask

    task automatic test_errors();
        logic [63:0] d; logic e;
        cfg_read(12'h004, d, e);
        tests_run++;
        if ({e, d} !== {1'b1, 64'h0}) begin
            tests_failed++; $display("FAIL unaligned_read: got err=%b %h expected err=1 0", e, d);
        end
        cfg_read(12'h160, d, e);
        tests_run++;
        if ({e, d} !== {1'b1, 64'h0}) begin
            tests_failed++; $display("FAIL range_read: got err=%b %h expected err=1 0", e, d);
        end
        cfg_write(12'h200, 64'h1234, e);
        tests_run++;
        if (e !== 1'b1) begin
            tests_failed++; $display("FAIL range_write: got err=%b expected 1", e);
        end
        cfg_write(12'h090, 64'h79, e);
        cfg_read(12'h090, d, e);
        tests_run++;
        if ({e, d} !== {1'b0, 64'h09}) begin
            tests_failed++; $display("FAIL attr_rsvd_mask: got err=%b %h expected err=0 09", e, d);
        end
    endtask

    task automatic test_wrap();
        logic h; logic [3:0] i; logic [7:0] a; int lat; logic e;
        cfg_write(12'h000, 64'hFFFF_FFFF_FFFF_F000, e);
        cfg_write(12'h008, 64'h2000, e);
        cfg_write(12'h010, 64'h01, e);
        lookup(64'h0000_0000_0000_0800, h, i, a, lat);
        tests_run++;
        if ({h, i, a} !== {1'b1, 4'd0, 8'h01}) begin
            tests_failed++; $display("FAIL wrap_low: got %b/%0d/%h expected 1/0/01", h, i, a);
        end
        lookup(64'hFFFF_FFFF_FFFF_F800, h, i, a, lat);
        tests_run++;
        if ({h, i, a} !== {1'b1, 4'd0, 8'h01}) begin
            tests_failed++; $display("FAIL wrap_high: got %b/%0d/%h expected 1/0/01", h, i, a);
        end
        lookup(64'h0000_0000_0000_1000, h, i, a, lat);
        tests_run++;
        if ({h, i, a} !== {1'b0, 4'd0, 8'h00}) begin
            tests_failed++; $display("FAIL wrap_end: got %b/%0d/%h expected 0/0/00", h, i, a);
        end
    endtask

    task automatic test_lock();
        logic h; logic [3:0] i; logic [7:0] a; int lat; logic [63:0] d; logic e;
        cfg_write(12'h070, 64'h81, e);
        tests_run++;
        if (e !== 1'b0) begin
            tests_failed++; $display("FAIL lock_set: got err=%b expected 0", e);
        end
        cfg_write(12'h060, 64'h1234_0000, e);
        tests_run++;
        if (e !== 1'b1) begin
            tests_failed++; $display("FAIL locked_write: got err=%b expected 1", e);
        end
        cfg_read(12'h060, d, e);
        tests_run++;
        if ({e, d} !== {1'b0, 64'h0C00_0000}) begin
            tests_failed++; $display("FAIL locked_base: got err=%b %h expected err=0 %h", e, d, 64'h0C00_0000);
        end
        lookup(64'h0C00_0000, h, i, a, lat);
        tests_run++;
        if ({h, i, a} !== {1'b1, 4'd3, 8'h81}) begin
            tests_failed++; $display("FAIL locked_lookup: got %b/%0d/%h expected 1/3/81", h, i, a);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] addrs [4];
        logic [12:0] exp_r [4];
        int tx, rx, cyc;
        logic do_tx, do_rx;
        addrs[0] = 64'h8000_0000; exp_r[0] = {1'b1, 4'd10, 8'h07};
        addrs[1] = 64'h1000_0000; exp_r[1] = {1'b1, 4'd4,  8'h09};
        addrs[2] = 64'h6000_0000; exp_r[2] = {1'b0, 4'd0,  8'h00};
        addrs[3] = 64'h0001_0000; exp_r[3] = {1'b1, 4'd1,  8'h09};
        tx = 0; rx = 0; cyc = 0;
        resp_ready = 1'b0;
        while (tx < 2 && cyc < 20) begin
            req_valid = 1'b1; req_addr = addrs[tx]; #1;
            do_tx = req_ready;
            @(posedge clk); #1; cyc++;
            if (do_tx) tx++;
        end
        req_valid = 1'b1; req_addr = addrs[tx]; #1;
        tests_run++;
        if (tx !== 2 || req_ready !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_fill: got accepted=%0d ready=%b expected 2/0", tx, req_ready);
        end
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if ({resp_valid, req_ready, resp_hit, resp_idx, resp_attr} !== {2'b10, exp_r[0]}) begin
                tests_failed++;
                $display("FAIL b2b_hold%0d: got v=%b r=%b %h expected v=1 r=0 %h", c, resp_valid, req_ready,
                         {resp_hit, resp_idx, resp_attr}, exp_r[0]);
            end
            @(posedge clk); #2;
        end
        resp_ready = 1'b1; cyc = 0;
        while (rx < 4 && cyc < 30) begin
            if (tx < 4) begin
                req_valid = 1'b1; req_addr = addrs[tx];
            end else begin
                req_valid = 1'b0;
            end
            #1;
            do_tx = req_valid && req_ready;
            do_rx = resp_valid && resp_ready;
            if (do_rx) begin
                tests_run++;
                if ({resp_hit, resp_idx, resp_attr} !== exp_r[rx]) begin
                    tests_failed++;
                    $display("FAIL b2b_resp%0d: got %h expected %h", rx, {resp_hit, resp_idx, resp_attr}, exp_r[rx]);
                end
                rx++;
            end
            @(posedge clk); #1; cyc++;
            if (do_tx) tx++;
        end
        req_valid = 1'b0;
        tests_run++;
        if (rx !== 4 || tx !== 4) begin
            tests_failed++; $display("FAIL b2b_count: got rx=%0d tx=%0d expected 4/4", rx, tx);
        end
    endtask

    task automatic test_same_cycle();
        logic h; logic [3:0] i; logic [7:0] a; int lat;
        resp_ready = 1'b1;
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 12'h130; cfg_wdata = 64'h0;
        req_valid = 1'b1; req_addr = 64'h5000_0000; #1;
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL same_ready: got %b expected 1", req_ready);
        end
        @(posedge clk); #1;
        cfg_req = 1'b0; cfg_we = 1'b0; req_valid = 1'b0;
        tests_run++;
        if ({cfg_rvalid, cfg_err} !== 2'b10) begin
            tests_failed++; $display("FAIL same_cfg: got %b expected 10", {cfg_rvalid, cfg_err});
        end
        @(posedge clk); #1;
        tests_run++;
        if ({resp_valid, resp_hit, resp_idx, resp_attr} !== {2'b11, 4'd9, 8'h09}) begin
            tests_failed++;
            $display("FAIL same_prewrite: got %b/%b/%0d/%h expected 1/1/9/09", resp_valid, resp_hit, resp_idx, resp_attr);
        end
        @(posedge clk); #1;
        lookup(64'h5000_0000, h, i, a, lat);
        tests_run++;
        if ({h, i, a} !== {1'b0, 4'd0, 8'h00}) begin
            tests_failed++; $display("FAIL same_postwrite: got %b/%0d/%h expected 0/0/00", h, i, a);
        end
    endtask

    task automatic test_overlap();
        logic h; logic [3:0] i; logic [7:0] a; int lat; logic e;
        cfg_write(12'h040, 64'h4000_0000, e);
        cfg_write(12'h048, 64'h100, e);
        cfg_write(12'h050, 64'h05, e);
        cfg_write(12'h0A0, 64'h4000_0000, e);
        cfg_write(12'h0A8, 64'h1000, e);
        cfg_write(12'h0B0, 64'h01, e);
        lookup(64'h4000_0000, h, i, a, lat);
        tests_run++;
        if ({h, i, a} !== {1'b1, 4'd2, 8'h05}) begin
            tests_failed++; $display("FAIL overlap_low: got %b/%0d/%h expected 1/2/05", h, i, a);
        end
        lookup(64'h4000_0100, h, i, a, lat);
        tests_run++;
        if ({h, i, a} !== {1'b1, 4'd5, 8'h01}) begin
            tests_failed++; $display("FAIL overlap_next: got %b/%0d/%h expected 1/5/01", h, i, a);
        end
    endtask

    task automatic test_reset_mid();
        logic h; logic [3:0] i; logic [7:0] a; int lat; logic [63:0] d; logic e;
        resp_ready = 1'b1; req_valid = 1'b1; req_addr = 64'h8000_0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        tests_run++;
        if ({resp_valid, req_ready, resp_hit, resp_idx, resp_attr} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset: got v=%b r=%b %h expected all zero", resp_valid, req_ready,
                     {resp_hit, resp_idx, resp_attr});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (resp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL mid_flush: got %b expected 0", resp_valid);
        end
        cfg_read(12'h000, d, e);
        tests_run++;
        if ({e, d} !== {1'b0, 64'h0}) begin
            tests_failed++; $display("FAIL reload_base0: got err=%b %h expected err=0 0", e, d);
        end
        cfg_read(12'h070, d, e);
        tests_run++;
        if ({e, d} !== {1'b0, 64'h09}) begin
            tests_failed++; $display("FAIL reload_attr3: got err=%b %h expected err=0 09", e, d);
        end
        cfg_write(12'h060, 64'h0C00_0000, e);
        tests_run++;
        if (e !== 1'b0) begin
            tests_failed++; $display("FAIL unlock_write: got err=%b expected 0", e);
        end
        cfg_read(12'h3F8, d, e);
        tests_run++;
        if ({e, d} !== {1'b0, 64'h0}) begin
            tests_failed++; $display("FAIL reload_miss_cnt: got err=%b %0d expected err=0 0", e, d);
        end
        lookup(64'h4000_0000, h, i, a, lat);
        tests_run++;
        if ({h, i, a} !== {1'b1, 4'd8, 8'h09} || lat !== 2) begin
            tests_failed++; $display("FAIL reload_lookup: got %b/%0d/%h lat %0d expected 1/8/09 lat 2", h, i, a, lat);
        end
    endtask

    initial begin
        test_reset();
        test_dram_lookup();
        test_miss();
        test_errors();
        test_wrap();
        test_lock();
        test_back_to_back();
        test_same_cycle();
        test_overlap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
